run_sequencer: RTL and testbench

- Host-side controller directly upstream of the 9-bit processor core.
- Drives the core's reset and start pins and watches its done flag (Ack).
- Sequences a batch of back-to-back program runs, measures each run's cycle count, and flags hangs with a watchdog.
- Sits between the bench/host and the processor top level and is the only block that toggles the core's Reset/Start.

---
 rtl/run_seq_pkg.sv | 21 ++
 rtl/sat_counter.sv | 25 ++
 rtl/run_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_run_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run sequencer.
package run_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RSTCPU = 3'd1,
    START  = 3'd2,
    WCLR   = 3'd3,
    RUN    = 3'd4,
    NEXT   = 3'd5,
    DONE   = 3'd6
  } runState_t;

  localparam int unsigned RST_CYCLES_D   = 2;
  localparam int unsigned START_CYCLES_D = 1;
  localparam int unsigned CLR_LIMIT_D    = 4;
  localparam int unsigned MAX_CYCLES_D   = 32'h0000_FFFF;
  localparam int unsigned CW_D           = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for run length and phase timing.
module sat_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count,
  output logic          atLimit
);

  assign atLimit = (count == limit);

  // Count up while enabled, hold at limit, clear has priority
  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (enable && !atLimit) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Host-side run sequencer for the 9-bit core: resets the core once per batch,
// pulses Start for each run, times each run and flags hangs.
// Optional log RAM of per-run cycle counts enabled by defining RUN_SEQ_LOG_EN.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = RST_CYCLES_D,
  parameter int unsigned START_CYCLES = START_CYCLES_D,
  parameter int unsigned CLR_LIMIT    = CLR_LIMIT_D,
  parameter int unsigned MAX_CYCLES   = MAX_CYCLES_D,
  parameter int unsigned CW           = CW_D
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          HostGo,
  input  logic [3:0]    NumRuns,
  input  logic          CpuAck,
  output logic          CpuReset,
  output logic          CpuStart,
  output logic          Busy,
  output logic          Done,
  output logic [3:0]    RunIdx,
  output logic [CW-1:0] CycleCount,
  output logic          CountValid,
  output logic          Timeout,
  output logic          Error
`ifdef RUN_SEQ_LOG_EN
  ,
  input  logic [3:0]    LogAddr,
  output logic [CW-1:0] LogData
`endif
);

  runState_t     state;
  logic [3:0]    runTotal;

  logic [CW-1:0] phaseCnt;
  logic [CW-1:0] phaseLimit;
  logic          phaseAtLimit;
  logic          phaseEn;
  logic          phaseClr;

  logic [CW-1:0] runCnt;
  logic          runAtLimit;
  logic          runEn;
  logic          runClr;
  logic          wclrExpired;

  // Phase timer limits: the timer reaches its limit on the last cycle of a timed state
  always_comb begin
    phaseLimit  = '0;
    phaseEn     = 1'b0;
    case (state)
      RSTCPU: begin phaseLimit = CW'(RST_CYCLES - 1);   phaseEn = 1'b1; end
      START:  begin phaseLimit = CW'(START_CYCLES - 1); phaseEn = 1'b1; end
      WCLR:   begin phaseLimit = CW'(CLR_LIMIT - 1);    phaseEn = 1'b1; end
      default: ;
    endcase
    wclrExpired = (phaseCnt == CW'(CLR_LIMIT - 1));
    phaseClr    = !phaseEn || phaseAtLimit || (state == WCLR && !CpuAck);
  end

  // Run counter runs only inside RUN while the core is still busy
  always_comb begin
    runClr = (state != RUN);
    runEn  = (state == RUN) && !CpuAck;
  end

  sat_counter #(.CW(CW)) uPhaseTimer (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (phaseClr),
    .enable  (phaseEn),
    .limit   (phaseLimit),
    .count   (phaseCnt),
    .atLimit (phaseAtLimit)
  );

  sat_counter #(.CW(CW)) uRunCounter (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (runClr),
    .enable  (runEn),
    .limit   (CW'(MAX_CYCLES)),
    .count   (runCnt),
    .atLimit (runAtLimit)
  );

  // Batch FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      runTotal   <= '0;
      CpuReset   <= 1'b0;
      CpuStart   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      RunIdx     <= '0;
      CycleCount <= '0;
      CountValid <= 1'b0;
      Timeout    <= 1'b0;
      Error      <= 1'b0;
    end else begin
      CountValid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (HostGo) begin
            runTotal <= (NumRuns == 4'd0) ? 4'd1 : NumRuns;
            Done     <= 1'b0;
            Timeout  <= 1'b0;
            Error    <= 1'b0;
            RunIdx   <= '0;
            CpuReset <= 1'b1;
            Busy     <= 1'b1;
            state    <= RSTCPU;
          end
        end
        RSTCPU: begin
          if (phaseAtLimit) begin
            CpuReset <= 1'b0;
            CpuStart <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (phaseAtLimit) begin
            CpuStart <= 1'b0;
            state    <= WCLR;
          end
        end
        WCLR: begin
          if (!CpuAck) begin
            state <= RUN;
          end else if (wclrExpired) begin
            Error <= 1'b1;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        RUN: begin
          if (CpuAck) begin
            CycleCount <= runCnt;
            CountValid <= 1'b1;
            state      <= NEXT;
          end else if (runAtLimit) begin
            Timeout    <= 1'b1;
            CycleCount <= CW'(MAX_CYCLES);
            CountValid <= 1'b1;
            Busy       <= 1'b0;
            Done       <= 1'b1;
            state      <= DONE;
          end
        end
        NEXT: begin
          if ((5'(RunIdx) + 5'd1) < 5'(runTotal)) begin
            RunIdx   <= RunIdx + 4'd1;
            CpuStart <= 1'b1;
            state    <= START;
          end else begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RUN_SEQ_LOG_EN
  logic [CW-1:0] logRam [16];

  // Record each completed run's count at its run index; only Reset clears the log
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) logRam[i] <= '0;
    end else if (CountValid) begin
      logRam[RunIdx] <= CycleCount;
    end
  end

  assign LogData = logRam[LogAddr];
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with a small behavioural model of the core.
module tb_run_sequencer;
  import run_seq_pkg::*;

  localparam int unsigned CW = 16;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          HostGo = 1'b0;
  logic [3:0]    NumRuns = 4'd0;
  logic          CpuAck;
  logic          CpuReset, CpuStart, Busy, Done, CountValid, Timeout, Error;
  logic [3:0]    RunIdx;
  logic [CW-1:0] CycleCount;
`ifdef RUN_SEQ_LOG_EN
  logic [3:0]    LogAddr = 4'd0;
  logic [CW-1:0] LogData;
`endif

  int errors = 0;
  int checks = 0;

  // Core model controls
  int latTab [4];
  bit neverAck = 1'b0;
  bit stuckAck = 1'b0;
  logic ackM;
  logic startD;
  int rem;
  int startNum;

  // Monitor accumulators
  int rstCyc = 0;
  int startCyc = 0;
  int busyCyc = 0;
  int cvVals[$];
  int cvIdx[$];

  run_sequencer #(.MAX_CYCLES(100)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .HostGo     (HostGo),
    .NumRuns    (NumRuns),
    .CpuAck     (CpuAck),
    .CpuReset   (CpuReset),
    .CpuStart   (CpuStart),
    .Busy       (Busy),
    .Done       (Done),
    .RunIdx     (RunIdx),
    .CycleCount (CycleCount),
    .CountValid (CountValid),
    .Timeout    (Timeout),
    .Error      (Error)
`ifdef RUN_SEQ_LOG_EN
    ,
    .LogAddr    (LogAddr),
    .LogData    (LogData)
`endif
  );

  initial forever #5 Clk = ~Clk;

  assign CpuAck = stuckAck ? 1'b1 : ackM;

  // Core model: Ack drops when Start is seen, rises lat+1 cycles later
  always @(posedge Clk) begin
    startD <= CpuStart;
    if (Reset || CpuReset) begin
      ackM     <= 1'b1;
      rem      <= 0;
      startNum <= 0;
    end else if (CpuStart && !startD) begin
      ackM     <= 1'b0;
      startNum <= startNum + 1;
      rem      <= neverAck ? 0 : latTab[startNum] + 1;
    end else if (rem != 0) begin
      rem <= rem - 1;
      if (rem == 1) ackM <= 1'b1;
    end
  end

  // Output monitor sampled mid-cycle
  always @(negedge Clk) begin
    if (CpuReset === 1'b1) rstCyc++;
    if (CpuStart === 1'b1) startCyc++;
    if (Busy === 1'b1) busyCyc++;
    if (CountValid === 1'b1) begin
      cvVals.push_back(int'(CycleCount));
      cvIdx.push_back(int'(RunIdx));
    end
  end

  task automatic start_batch(input logic [3:0] n);
    @(negedge Clk);
    HostGo  = 1'b1;
    NumRuns = n;
    @(negedge Clk);
    HostGo  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({CpuReset, CpuStart, Busy, Done, RunIdx, CycleCount, CountValid, Timeout, Error} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {CpuReset, CpuStart, Busy, Done, RunIdx, CycleCount, CountValid, Timeout, Error});
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE);
    end
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_single;
    int rb, sb, bb, cb;
    bit ok;
    latTab[0] = 37;
    rb = rstCyc; sb = startCyc; bb = busyCyc; cb = cvVals.size();
    start_batch(4'd1);
    checks++;
    if (Busy !== 1'b1 || CpuReset !== 1'b1) begin
      errors++;
      $display("FAIL single_go: got Busy=%b CpuReset=%b expected 1 1", Busy, CpuReset);
    end
    wait_done(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done: got no Done expected Done within 300 cycles"); end
    repeat (2) @(negedge Clk);
    checks++;
    if (rstCyc - rb != 2) begin errors++; $display("FAIL single_rst_cycles: got %0d expected 2", rstCyc - rb); end
    checks++;
    if (startCyc - sb != 1) begin errors++; $display("FAIL single_start_cycles: got %0d expected 1", startCyc - sb); end
    checks++;
    if (cvVals.size() - cb != 1) begin
      errors++; $display("FAIL single_strobes: got %0d expected 1", cvVals.size() - cb);
    end else begin
      checks++;
      if (cvVals[cb] != 37) begin errors++; $display("FAIL single_count: got %0d expected 37", cvVals[cb]); end
    end
    checks++;
    if (busyCyc - bb != 43) begin errors++; $display("FAIL single_busy_cycles: got %0d expected 43", busyCyc - bb); end
    checks++;
    if ({Done, Busy, Timeout, Error} !== 4'b1000) begin
      errors++; $display("FAIL single_flags: got %b expected 1000", {Done, Busy, Timeout, Error});
    end
  endtask

  task automatic test_multi;
    int rb, sb, bb, cb;
    bit ok;
    int expV [3];
    expV = '{10, 20, 30};
    latTab[0] = 10; latTab[1] = 20; latTab[2] = 30;
    rb = rstCyc; sb = startCyc; bb = busyCyc; cb = cvVals.size();
    start_batch(4'd3);
    wait_done(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL multi_done: got no Done expected Done within 400 cycles"); end
    repeat (2) @(negedge Clk);
    checks++;
    if (cvVals.size() - cb != 3) begin
      errors++; $display("FAIL multi_strobes: got %0d expected 3", cvVals.size() - cb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cvVals[cb+i] != expV[i] || cvIdx[cb+i] != i) begin
          errors++;
          $display("FAIL multi_run%0d: got count=%0d idx=%0d expected count=%0d idx=%0d",
                   i, cvVals[cb+i], cvIdx[cb+i], expV[i], i);
        end
      end
    end
    checks++;
    if (rstCyc - rb != 2) begin errors++; $display("FAIL multi_rst_cycles: got %0d expected 2", rstCyc - rb); end
    checks++;
    if (startCyc - sb != 3) begin errors++; $display("FAIL multi_start_cycles: got %0d expected 3", startCyc - sb); end
    checks++;
    if (busyCyc - bb != 74) begin errors++; $display("FAIL multi_busy_cycles: got %0d expected 74", busyCyc - bb); end
    checks++;
    if (RunIdx !== 4'd2 || Done !== 1'b1 || Busy !== 1'b0) begin
      errors++; $display("FAIL multi_end: got RunIdx=%0d Done=%b Busy=%b expected 2 1 0", RunIdx, Done, Busy);
    end
  endtask

  task automatic test_timeout;
    int bb, cb;
    bit ok;
    neverAck = 1'b1;
    bb = busyCyc; cb = cvVals.size();
    start_batch(4'd1);
    wait_done(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_done: got no Done expected Done within 400 cycles"); end
    repeat (2) @(negedge Clk);
    checks++;
    if ({Timeout, Error, Done} !== 3'b101) begin
      errors++; $display("FAIL timeout_flags: got T/E/D=%b expected 101", {Timeout, Error, Done});
    end
    checks++;
    if (CycleCount !== 16'd100) begin errors++; $display("FAIL timeout_count: got %0d expected 100", CycleCount); end
    checks++;
    if (cvVals.size() - cb != 1) begin errors++; $display("FAIL timeout_strobes: got %0d expected 1", cvVals.size() - cb); end
    checks++;
    if (busyCyc - bb != 105) begin errors++; $display("FAIL timeout_busy_cycles: got %0d expected 105", busyCyc - bb); end
    neverAck = 1'b0;
  endtask

  task automatic test_stuck;
    int bb, cb;
    bit ok;
    stuckAck = 1'b1;
    bb = busyCyc; cb = cvVals.size();
    start_batch(4'd2);
    wait_done(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stuck_done: got no Done expected Done within 100 cycles"); end
    repeat (2) @(negedge Clk);
    checks++;
    if ({Error, Timeout, Done, Busy} !== 4'b1010) begin
      errors++; $display("FAIL stuck_flags: got E/T/D/B=%b expected 1010", {Error, Timeout, Done, Busy});
    end
    checks++;
    if (cvVals.size() - cb != 0) begin errors++; $display("FAIL stuck_strobes: got %0d expected 0", cvVals.size() - cb); end
    checks++;
    if (busyCyc - bb != 7) begin errors++; $display("FAIL stuck_busy_cycles: got %0d expected 7", busyCyc - bb); end
    stuckAck = 1'b0;
  endtask

  task automatic test_hostgo_ignored;
    int rb, bb, cb;
    bit ok;
    latTab[0] = 8; latTab[1] = 12;
    rb = rstCyc; bb = busyCyc; cb = cvVals.size();
    start_batch(4'd2);
    repeat (10) @(negedge Clk);
    HostGo = 1'b1; NumRuns = 4'd5;
    @(negedge Clk);
    HostGo = 1'b0;
    checks++;
    if (RunIdx !== 4'd0 || CpuReset !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_go: got RunIdx=%0d CpuReset=%b Busy=%b expected 0 0 1", RunIdx, CpuReset, Busy);
    end
    wait_done(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ignore_done: got no Done expected Done within 300 cycles"); end
    repeat (2) @(negedge Clk);
    checks++;
    if (cvVals.size() - cb != 2) begin
      errors++; $display("FAIL ignore_strobes: got %0d expected 2", cvVals.size() - cb);
    end else begin
      checks++;
      if (cvVals[cb] != 8 || cvVals[cb+1] != 12) begin
        errors++; $display("FAIL ignore_counts: got %0d,%0d expected 8,12", cvVals[cb], cvVals[cb+1]);
      end
    end
    checks++;
    if (rstCyc - rb != 2 || busyCyc - bb != 30 || RunIdx !== 4'd1) begin
      errors++;
      $display("FAIL ignore_end: got rst=%0d busy=%0d RunIdx=%0d expected 2 30 1", rstCyc - rb, busyCyc - bb, RunIdx);
    end
  endtask

  task automatic test_reset_mid;
    int sb, bb, cb;
    bit ok;
    latTab[0] = 10; latTab[1] = 20; latTab[2] = 30;
    start_batch(4'd3);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (RunIdx === 4'd1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_reach_run1: got no RunIdx=1 expected within 200 cycles"); end
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if ({CpuReset, CpuStart, Busy, Done, RunIdx, CycleCount, CountValid, Timeout, Error} !== 27'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h expected 0",
               {CpuReset, CpuStart, Busy, Done, RunIdx, CycleCount, CountValid, Timeout, Error});
    end
    checks++;
    if (dut.state !== IDLE) begin errors++; $display("FAIL mid_reset_state: got %0d expected %0d", dut.state, IDLE); end
    Reset = 1'b0;
    @(negedge Clk);
    latTab[0] = 5;
    sb = startCyc; bb = busyCyc; cb = cvVals.size();
    start_batch(4'd0);
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_done: got no Done expected Done within 200 cycles"); end
    repeat (2) @(negedge Clk);
    checks++;
    if (cvVals.size() - cb != 1) begin
      errors++; $display("FAIL zero_strobes: got %0d expected 1", cvVals.size() - cb);
    end else begin
      checks++;
      if (cvVals[cb] != 5) begin errors++; $display("FAIL zero_count: got %0d expected 5", cvVals[cb]); end
    end
    checks++;
    if (startCyc - sb != 1 || busyCyc - bb != 11 || RunIdx !== 4'd0) begin
      errors++;
      $display("FAIL zero_end: got starts=%0d busy=%0d RunIdx=%0d expected 1 11 0", startCyc - sb, busyCyc - bb, RunIdx);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_multi;
    test_timeout;
    test_stuck;
    test_hostgo_ignored;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
